tick_bcd_counter: RTL and testbench
===================================

// Module: tick_bcd_counter
// PURPOSE
//   Consumer end of the tick_gen interface. Counts single-cycle o_tick pulses from tick_gen
//   into a 4-digit BCD value (0000..9999) with a parallel binary copy.
//   Supports up/down counting, synchronous clear, parallel load and a wrap pulse.
//   Sits between tick_gen and the FND display driver in the counter10000 datapath.
// PARAMETERS
//   N_DIGITS  4  number of BCD digits; fixed at 4 for this release (max count 9999)
//   BIN_W     14 width of o_count_bin; must satisfy 2^BIN_W > 10^N_DIGITS - 1
// PORTS
//   clk          in   1   system clock; all state changes on its rising edge
//   rst          in   1   reset, synchronous, active-high
//   i_tick       in   1   count strobe from tick_gen o_tick; one clk cycle wide
//   i_clear      in   1   synchronous clear of the count to 0000
//   i_mode       in   1   0 = count up, 1 = count down
//   i_load       in   1   single-cycle load strobe
//   i_load_bcd   in   16  load value, 4 BCD nibbles, [15:12] = thousands
//   o_bcd        out  16  current count, BCD, [3:0] = ones
//   o_count_bin  out  14  current count, binary; always equals the decimal value of o_bcd
//   o_wrap       out  1   one-cycle pulse on 9999->0000 (up) or 0000->9999 (down)
// BEHAVIOUR
//   - All outputs are registered. On reset: o_bcd = 16'h0000, o_count_bin = 0, o_wrap = 0.
//   - Priority, evaluated every clk edge: rst > i_clear > i_load > i_tick.
//     Only the highest-priority active event takes effect.
//   - i_clear: count <= 0000, o_wrap <= 0. A coincident tick or load is dropped.
//   - i_load: each nibble of i_load_bcd > 9 saturates to 9 (e.g. 16'h3A7F -> 3979).
//     o_bcd <= saturated value; o_count_bin <= d3*1000 + d2*100 + d1*10 + d0.
//     o_wrap <= 0. A coincident tick is dropped.
//   - i_tick with i_mode = 0: ones digit +1. A digit at 9 goes to 0 and carries into the
//     next digit. 9999 -> 0000, with o_wrap = 1 for exactly that one cycle.
//   - i_tick with i_mode = 1: ones digit -1. A digit at 0 goes to 9 and borrows from the
//     next digit. 0000 -> 9999, with o_wrap = 1 for exactly that one cycle.
//   - Latency: o_bcd, o_count_bin and o_wrap reflect an event on the clk edge that samples it.
//     Values are visible in the next cycle; no further pipelining.
//   - With no event active, count holds and o_wrap = 0. o_wrap is never high two cycles in a row
//     unless ticks arrive on back-to-back cycles at the boundary.
//   - Back-to-back ticks on consecutive cycles are legal; each one counts.
//   - i_mode is sampled only on tick cycles. A mode change takes effect on the next tick;
//     the count itself is unaffected.
//   - o_count_bin is updated by its own +1/-1 counter in lockstep with o_bcd.
//     On a wrap it becomes 0 (up) or 9999 (down); it is never derived from o_bcd combinationally.
//   - rst mid-count discards all state. Counting restarts from 0000 on the first tick after
//     rst deasserts.
// TESTING
//   1. rst held 2 cycles, then released -> o_bcd = 16'h0000, o_count_bin = 0, o_wrap = 0.
//   2. mode = 0, 10 ticks -> o_bcd = 16'h0010. Then 90 more ticks -> 16'h0100,
//      o_count_bin = 100, o_wrap never asserted.
//   3. Load 16'h9998, mode = 0, 2 ticks -> 9999, then 0000. o_wrap = 1 for the single cycle
//      after the 2nd tick. o_count_bin goes 9999 -> 0.
//   4. Load 16'h0001, mode = 1, 2 ticks -> 0000, then 9999 with a one-cycle o_wrap.
//      1 more tick -> 9998.
//   5. Load 16'hFA5B -> o_bcd = 16'h9959, o_count_bin = 9959.
//      Then i_clear and i_tick in the same cycle -> 0000 (tick dropped).
//   6. i_load with i_load_bcd = 16'h0500 and i_tick in the same cycle -> 0500 (tick dropped).
//      Then rst in the middle of a 20-tick burst -> 0000, and counting resumes from 0000.
//   Scoreboard every cycle: o_count_bin == decimal(o_bcd), and every nibble of o_bcd <= 9.

Source files
------------

// File: rtl/tick_bcd_counter.sv
// Four-digit BCD up/down tick counter with a parallel binary copy, clear, load and wrap pulse.
// Digits step through a ripple carry/borrow chain; the binary copy runs as its own counter.

module bcd_digit_step (
  input  logic       en_i,
  input  logic       down_i,
  input  logic [3:0] d_i,
  output logic [3:0] d_o,
  output logic       cy_o
);
  always_comb begin
    d_o  = d_i;
    cy_o = 1'b0;
    if (en_i) begin
      if (!down_i) begin
        if (d_i >= 4'd9) begin
          d_o  = 4'd0;
          cy_o = 1'b1;
        end else begin
          d_o = d_i + 4'd1;
        end
      end else begin
        if (d_i == 4'd0) begin
          d_o  = 4'd9;
          cy_o = 1'b1;
        end else begin
          d_o = d_i - 4'd1;
        end
      end
    end
  end
endmodule

module tick_bcd_counter #(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_tick,
  input  logic                  i_clear,
  input  logic                  i_mode,
  input  logic                  i_load,
  input  logic [4*N_DIGITS-1:0] i_load_bcd,
  output logic [4*N_DIGITS-1:0] o_bcd,
  output logic [BIN_W-1:0]      o_count_bin,
  output logic                  o_wrap
);
  localparam int MAX_CNT = 10**N_DIGITS - 1;

  logic [N_DIGITS-1:0][3:0] bcd_q, bcd_d, step_bcd, load_sat;
  logic [N_DIGITS:0]        en_chain;
  logic [BIN_W-1:0]         bin_q, bin_d, bin_step, load_bin;
  logic                     wrap_q, wrap_d;

  // en_chain[g] is high when every digit below g rolls over on this tick
  assign en_chain[0] = 1'b1;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    bcd_digit_step u_step (
      .en_i   (en_chain[g]),
      .down_i (i_mode),
      .d_i    (bcd_q[g]),
      .d_o    (step_bcd[g]),
      .cy_o   (en_chain[g+1])
    );
    assign load_sat[g] = (i_load_bcd[4*g +: 4] > 4'd9) ? 4'd9 : i_load_bcd[4*g +: 4];
  end

  always_comb begin
    load_bin = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--)
      load_bin = load_bin * BIN_W'(10) + BIN_W'(load_sat[i]);
  end

  always_comb begin
    bin_step = bin_q;
    if (!i_mode) bin_step = (bin_q == BIN_W'(MAX_CNT)) ? '0 : bin_q + BIN_W'(1);
    else         bin_step = (bin_q == '0) ? BIN_W'(MAX_CNT) : bin_q - BIN_W'(1);
  end

  always_comb begin
    bcd_d  = bcd_q;
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (i_clear) begin
      bcd_d = '0;
      bin_d = '0;
    end else if (i_load) begin
      bcd_d = load_sat;
      bin_d = load_bin;
    end else if (i_tick) begin
      bcd_d  = step_bcd;
      bin_d  = bin_step;
      wrap_d = en_chain[N_DIGITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      bin_q  <= bin_d;
      wrap_q <= wrap_d;
    end
  end

  assign o_bcd       = bcd_q;
  assign o_count_bin = bin_q;
  assign o_wrap      = wrap_q;
endmodule

// File: tb/tb_tick_bcd_counter.sv
// Bench for tick_bcd_counter: integer reference model, per-cycle compare, directed and random stimulus.
module tb_tick_bcd_counter;
  logic        clk = 1'b0;
  logic        rst, i_tick, i_clear, i_mode, i_load;
  logic [15:0] i_load_bcd;
  logic [15:0] o_bcd;
  logic [13:0] o_count_bin;
  logic        o_wrap;

  int  vectors = 0, miscompares = 0;
  int  m_cnt = 0;
  bit  m_wrap = 1'b0;
  bit  chk = 1'b0;

  tick_bcd_counter dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_clear(i_clear), .i_mode(i_mode),
    .i_load(i_load), .i_load_bcd(i_load_bcd), .o_bcd(o_bcd),
    .o_count_bin(o_count_bin), .o_wrap(o_wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int c);
    return 16'(((c / 1000) % 10) << 12 | ((c / 100) % 10) << 8 | ((c / 10) % 10) << 4 | (c % 10));
  endfunction

  function automatic int sat_dec(input logic [15:0] v);
    int r = 0, mul = 1;
    for (int k = 0; k < 4; k++) begin
      int d = int'((v >> (4 * k)) & 16'hF);
      if (d > 9) d = 9;
      r += d * mul;
      mul *= 10;
    end
    return r;
  endfunction

  // Reference model: count as a plain integer modulo 10000
  always @(posedge clk) begin
    if (rst || i_clear) begin
      m_cnt = 0; m_wrap = 1'b0;
    end else if (i_load) begin
      m_cnt = sat_dec(i_load_bcd); m_wrap = 1'b0;
    end else if (i_tick) begin
      if (!i_mode) begin m_wrap = (m_cnt == 9999); m_cnt = (m_cnt + 1) % 10000; end
      else         begin m_wrap = (m_cnt == 0);    m_cnt = (m_cnt + 9999) % 10000; end
    end else begin
      m_wrap = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      int dec;
      dec = int'(o_bcd[15:12]) * 1000 + int'(o_bcd[11:8]) * 100 + int'(o_bcd[7:4]) * 10 + int'(o_bcd[3:0]);
      vectors++;
      if (o_bcd !== to_bcd(m_cnt) || o_count_bin !== 14'(m_cnt) || o_wrap !== m_wrap) begin
        miscompares++;
        $display("FAIL model t=%0t bcd=%h bin=%0d wrap=%b expected bcd=%h bin=%0d wrap=%b",
                 $time, o_bcd, o_count_bin, o_wrap, to_bcd(m_cnt), m_cnt, m_wrap);
      end
      vectors++;
      if (o_bcd[15:12] > 9 || o_bcd[11:8] > 9 || o_bcd[7:4] > 9 || o_bcd[3:0] > 9 ||
          int'(o_count_bin) != dec) begin
        miscompares++;
        $display("FAIL consistency t=%0t bcd=%h bin=%0d required valid nibbles and bin=%0d",
                 $time, o_bcd, o_count_bin, dec);
      end
    end
  end

  task automatic apply(input bit r, input bit t, input bit c, input bit l,
                       input logic [15:0] v, input bit m);
    @(negedge clk);
    rst = r; i_tick = t; i_clear = c; i_load = l; i_load_bcd = v; i_mode = m;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 16'h0, i_mode);
  endtask

  task automatic expect_lit(input string name, input logic [15:0] b, input int bin, input bit w);
    vectors++;
    if (o_bcd !== b || o_count_bin !== 14'(bin) || o_wrap !== w) begin
      miscompares++;
      $display("FAIL %s got bcd=%h bin=%0d wrap=%b required bcd=%h bin=%0d wrap=%b",
               name, o_bcd, o_count_bin, o_wrap, b, bin, w);
    end
  endtask

  initial begin
    rst = 1; i_tick = 0; i_clear = 0; i_load = 0; i_load_bcd = 0; i_mode = 0;
    @(negedge clk); @(negedge clk);
    chk = 1'b1;
    idle();
    expect_lit("reset", 16'h0000, 0, 0);

    // up counting through digit carries
    for (int i = 0; i < 10; i++) apply(0, 1, 0, 0, 16'h0, 0);
    idle();
    expect_lit("up10", 16'h0010, 10, 0);
    for (int i = 0; i < 90; i++) apply(0, 1, 0, 0, 16'h0, 0);
    idle();
    expect_lit("up100", 16'h0100, 100, 0);

    // up wrap
    apply(0, 0, 0, 1, 16'h9998, 0);
    apply(0, 1, 0, 0, 16'h0, 0);
    idle();
    expect_lit("up9999", 16'h9999, 9999, 0);
    apply(0, 1, 0, 0, 16'h0, 0);
    idle();
    expect_lit("upwrap", 16'h0000, 0, 1);
    idle();
    expect_lit("upwrap_end", 16'h0000, 0, 0);

    // down wrap
    apply(0, 0, 0, 1, 16'h0001, 1);
    apply(0, 1, 0, 0, 16'h0, 1);
    idle();
    expect_lit("down0", 16'h0000, 0, 0);
    apply(0, 1, 0, 0, 16'h0, 1);
    idle();
    expect_lit("downwrap", 16'h9999, 9999, 1);
    apply(0, 1, 0, 0, 16'h0, 1);
    idle();
    expect_lit("down9998", 16'h9998, 9998, 0);

    // saturating load, clear beats tick
    apply(0, 0, 0, 1, 16'hFA5B, 0);
    idle();
    expect_lit("loadsat", 16'h9959, 9959, 0);
    apply(0, 1, 1, 0, 16'h0, 0);
    idle();
    expect_lit("clrtick", 16'h0000, 0, 0);

    // load beats tick, then reset mid-burst
    apply(0, 1, 0, 1, 16'h0500, 0);
    idle();
    expect_lit("loadtick", 16'h0500, 500, 0);
    for (int i = 0; i < 20; i++) apply(i == 10, 1, 0, 0, 16'h0, 0);
    idle();
    expect_lit("rstburst", 16'h0009, 9, 0);

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] v;
      int sel;
      sel = $urandom_range(0, 4);
      case (sel)
        0: v = 16'h9999;
        1: v = 16'h0000;
        2: v = 16'h9998;
        3: v = 16'h0001;
        default: v = 16'($urandom);
      endcase
      apply($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
            v, (i / 300) % 2 == 1 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0));
    end
    idle();
    idle();
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
